jk_step_conditioner: RTL



---
 rtl/jk_step_conditioner_if.sv | 23 ++
 rtl/jk_step_conditioner.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/jk_step_conditioner_if.sv
// Pushbutton/switch inputs and latch-side outputs of the JK step conditioner.
interface jk_step_conditioner_if #(
  parameter int COUNT_W = 8
);
  logic               key_n;
  logic               sw_j;
  logic               sw_k;
  logic               j_out;
  logic               k_out;
  logic               step_level;
  logic               step_pulse;
  logic [COUNT_W-1:0] step_count;

  modport master (
    output key_n, sw_j, sw_k,
    input  j_out, k_out, step_level, step_pulse, step_count
  );

  modport slave (
    input  key_n, sw_j, sw_k,
    output j_out, k_out, step_level, step_pulse, step_count
  );
endinterface

// File: rtl/jk_step_conditioner.sv
// Debounced step level/pulse, step counter and frozen J/K for the gated JK latch lab.
// Define JK_STEP_REPEAT_EN to auto-repeat the step every REPEAT_CYCLES while the key is held.
module jk_step_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 25000000,
  parameter int COUNT_W         = 8
) (
  input logic                  clock,
  input logic                  reset,
  jk_step_conditioner_if.slave bus
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 3) begin : g_param_check
    $error("jk_step_conditioner: DEBOUNCE_CYCLES must be >= 2 and REPEAT_CYCLES >= 3");
  end

  logic               key_meta_q, key_sync_q;
  logic               j_meta_q, j_sync_q;
  logic               k_meta_q, k_sync_q;
  logic               key_s;

  state_e             state_q, state_d;
  logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
  logic               level_q, level_d;
  logic               pulse_q, pulse_d;
  logic               gap_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               j_q, k_q;

`ifdef JK_STEP_REPEAT_EN
  localparam int               REP_W    = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_GAP  = REP_W'(REPEAT_CYCLES - 2);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0]            rep_cnt_q, rep_cnt_d;
`endif

  // Key synchronizer idles at "released" so reset never looks like a press.
  // NOTE: sequential state uses <= so every flop samples the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
      j_meta_q   <= 1'b0;
      j_sync_q   <= 1'b0;
      k_meta_q   <= 1'b0;
      k_sync_q   <= 1'b0;
    end else begin
      key_meta_q <= bus.key_n;
      key_sync_q <= key_meta_q;
      j_meta_q   <= bus.sw_j;
      j_sync_q   <= j_meta_q;
      k_meta_q   <= bus.sw_k;
      k_sync_q   <= k_meta_q;
    end
  end

  assign key_s = ~key_sync_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    db_cnt_d  = db_cnt_q;
    pulse_d   = 1'b0;
    gap_d     = 1'b0;
`ifdef JK_STEP_REPEAT_EN
    rep_cnt_d = rep_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (key_s) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!key_s) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = PRESSED;
          pulse_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      PRESSED: begin
        if (!key_s) begin
          state_d = RELEASE_WAIT;
        end
`ifdef JK_STEP_REPEAT_EN
        // One low cycle of step_level, then a fresh step one period after the last.
        else if (rep_cnt_q == REP_LAST) begin
          pulse_d   = 1'b1;
          rep_cnt_d = '0;
        end else begin
          gap_d     = (rep_cnt_q == REP_GAP);
          rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
`endif
      end
      RELEASE_WAIT: begin
        if (key_s) begin
          state_d = PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      db_cnt_d  = '0;
`ifdef JK_STEP_REPEAT_EN
      rep_cnt_d = '0;
`endif
    end

    level_d = ((state_d == PRESSED) || (state_d == RELEASE_WAIT)) && !gap_d;
    count_d = pulse_d ? count_q + COUNT_W'(1) : count_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      pulse_q   <= 1'b0;
      count_q   <= '0;
      j_q       <= 1'b0;
      k_q       <= 1'b0;
`ifdef JK_STEP_REPEAT_EN
      rep_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      pulse_q   <= pulse_d;
      count_q   <= count_d;
`ifdef JK_STEP_REPEAT_EN
      rep_cnt_q <= rep_cnt_d;
`endif
      // J/K only follow the switches while the latch enable will be low next cycle.
      if (!level_d) begin
        j_q <= j_sync_q;
        k_q <= k_sync_q;
      end
    end
  end

  assign bus.j_out      = j_q;
  assign bus.k_out      = k_q;
  assign bus.step_level = level_q;
  assign bus.step_pulse = pulse_q;
  assign bus.step_count = count_q;

endmodule
